// File: rtl/serial_adder_ctrl.sv
// Serial adder sequencer: reuses one 2-bit adder slice to add two WIDTH-bit
// operands, least-significant digit first, with valid/ready on both sides.

module twoBitAdder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c,
    output logic [1:0] sum,
    output logic       carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {2'b00, c};
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [1:0]       slice_sum;
    logic             slice_carry;
    logic [WIDTH-1:0] part_next;

    twoBitAdder u_slice (
        .a     (a_sh_q[1:0]),
        .b     (b_sh_q[1:0]),
        .c     (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // New digit enters at the top so the final digit lands in [WIDTH-1:WIDTH-2]
    assign part_next = (part_q >> 2) | (WIDTH'(slice_sum) << (WIDTH - 2));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        part_d   = part_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    carry_d = cin;
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_sh_d  = a_sh_q >> 2;
                b_sh_d  = b_sh_q >> 2;
                part_d  = part_next;
                carry_d = slice_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    result_d = part_next;
                    cout_d   = slice_carry;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            part_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            part_q   <= part_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH 8, 2 and 16.

module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // WIDTH=8 instance
    logic       iv8, ir8, ci8, ov8, or8, co8, busy8;
    logic [7:0] a8, b8, r8;
    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .op_a(a8), .op_b(b8), .cin(ci8), .out_valid(ov8), .out_ready(or8),
        .result(r8), .cout(co8), .busy(busy8)
    );

    // WIDTH=2 instance
    logic       iv2, ir2, ci2, ov2, or2, co2, busy2;
    logic [1:0] a2, b2, r2;
    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .op_a(a2), .op_b(b2), .cin(ci2), .out_valid(ov2), .out_ready(or2),
        .result(r2), .cout(co2), .busy(busy2)
    );

    // WIDTH=16 instance
    logic        iv16, ir16, ci16, ov16, or16, co16, busy16;
    logic [15:0] a16, b16, r16;
    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .op_a(a16), .op_b(b16), .cin(ci16), .out_valid(ov16), .out_ready(or16),
        .result(r16), .cout(co16), .busy(busy16)
    );

    // One WIDTH=8 transaction; returns observed values and latency (-1 on timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic chg, output logic [7:0] res, output logic co,
                        output int lat);
        a8 = a; b8 = b; ci8 = ci; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        if (chg) begin a8 = 8'h11; b8 = 8'h11; end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ov8) begin lat = k; break; end
        end
        res = r8; co = co8;
        if (lat > 0) begin
            or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (ir8 !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ir8); end
        n_checks++; if (ov8 !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        n_checks++; if (r8 !== 8'h00)  begin n_fail++; $display("FAIL reset_result got=%h exp=00", r8); end
        n_checks++; if (co8 !== 1'b0)  begin n_fail++; $display("FAIL reset_cout got=%b exp=0", co8); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency_zero();
        logic [7:0] res; logic co; int lat;
        run8(8'h00, 8'h00, 1'b0, 1'b0, res, co, lat);
        n_checks++; if (lat != 4)      begin n_fail++; $display("FAIL zero_latency got=%0d exp=4", lat); end
        n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL zero_result got=%h exp=00", res); end
        n_checks++; if (co !== 1'b0)   begin n_fail++; $display("FAIL zero_cout got=%b exp=0", co); end
        n_checks++; if (ir8 !== 1'b1)  begin n_fail++; $display("FAIL zero_in_ready_after got=%b exp=1", ir8); end
        n_checks++; if (ov8 !== 1'b0)  begin n_fail++; $display("FAIL zero_out_valid_after got=%b exp=0", ov8); end
    endtask

    task automatic test_carry_chain();
        logic [7:0] res; logic co; int lat;
        run8(8'hFF, 8'h01, 1'b0, 1'b0, res, co, lat);
        n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL ripple_result got=%h exp=00", res); end
        n_checks++; if (co !== 1'b1)   begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", co); end
        run8(8'h3C, 8'h42, 1'b0, 1'b0, res, co, lat);
        n_checks++; if (res !== 8'h7E) begin n_fail++; $display("FAIL nostale_result got=%h exp=7e", res); end
        n_checks++; if (co !== 1'b0)   begin n_fail++; $display("FAIL nostale_cout got=%b exp=0", co); end
    endtask

    task automatic test_cin_and_hold();
        logic [7:0] res; logic co; int lat;
        run8(8'hA5, 8'h5A, 1'b1, 1'b1, res, co, lat);
        n_checks++; if (res !== 8'h00) begin n_fail++; $display("FAIL cin_result got=%h exp=00", res); end
        n_checks++; if (co !== 1'b1)   begin n_fail++; $display("FAIL cin_cout got=%b exp=1", co); end
        n_checks++; if (lat != 4)      begin n_fail++; $display("FAIL cin_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ov8) begin lat = k; break; end
        end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++; if (ov8 !== 1'b1)  begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, ov8); end
            n_checks++; if (r8 !== 8'h46)  begin n_fail++; $display("FAIL bp_result cyc=%0d got=%h exp=46", k, r8); end
            n_checks++; if (co8 !== 1'b0)  begin n_fail++; $display("FAIL bp_cout cyc=%0d got=%b exp=0", k, co8); end
            n_checks++; if (ir8 !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, ir8); end
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        n_checks++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL bp_handshake_valid got=%b exp=0", ov8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept_in_done got=%b exp=0", busy8); end
        @(posedge clk); #1;
        iv8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL bp_accept_in_idle got=%b exp=1", busy8); end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ov8) begin lat = k; break; end
        end
        n_checks++; if (lat != 4)     begin n_fail++; $display("FAIL bp_second_latency got=%0d exp=4", lat); end
        n_checks++; if (r8 !== 8'h03) begin n_fail++; $display("FAIL bp_second_result got=%h exp=03", r8); end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] res; logic co; int lat;
        a8 = 8'h55; b8 = 8'h22; ci8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", ov8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", busy8); end
        n_checks++; if (r8 !== 8'h00)   begin n_fail++; $display("FAIL arst_result got=%h exp=00", r8); end
        n_checks++; if (co8 !== 1'b0)   begin n_fail++; $display("FAIL arst_cout got=%b exp=0", co8); end
        n_checks++; if (ir8 !== 1'b1)   begin n_fail++; $display("FAIL arst_in_ready got=%b exp=1", ir8); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(8'h7F, 8'h01, 1'b0, 1'b0, res, co, lat);
        n_checks++; if (res !== 8'h80) begin n_fail++; $display("FAIL post_arst_result got=%h exp=80", res); end
        n_checks++; if (co !== 1'b0)   begin n_fail++; $display("FAIL post_arst_cout got=%b exp=0", co); end
        n_checks++; if (lat != 4)      begin n_fail++; $display("FAIL post_arst_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_width2_exhaustive();
        int lat;
        logic [2:0] exp;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(a); b2 = 2'(b); ci2 = 1'(c); iv2 = 1'b1;
                    exp = 3'(a + b + c);
                    @(posedge clk); #1;
                    iv2 = 1'b0;
                    lat = -1;
                    for (int k = 1; k <= 10; k++) begin
                        @(posedge clk); #1;
                        if (ov2) begin lat = k; break; end
                    end
                    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL w2_latency a=%0d b=%0d c=%0d got=%0d exp=1", a, b, c, lat); end
                    n_checks++; if ({co2, r2} !== exp) begin n_fail++; $display("FAIL w2_sum a=%0d b=%0d c=%0d got=%0d exp=%0d", a, b, c, {co2, r2}, exp); end
                    or2 = 1'b1;
                    @(posedge clk); #1;
                    or2 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_width16_random();
        logic [16:0] exp;
        int waited;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            exp = {1'b0, a16} + {1'b0, b16} + 17'(ci16);
            iv16 = 1'b1;
            @(posedge clk); #1;
            iv16 = 1'b0;
            waited = 0;
            while (!ov16 && waited < 30) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!ov16) begin
                n_checks++; n_fail++;
                $display("FAIL w16_timeout txn=%0d got=out_valid_low exp=out_valid_high", t);
            end else begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                n_checks++; if ({co16, r16} !== exp) begin n_fail++; $display("FAIL w16_sum txn=%0d got=%h exp=%h", t, {co16, r16}, exp); end
                or16 = 1'b1;
                @(posedge clk); #1;
                or16 = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 0; ci8 = 0; or8 = 0; a8 = '0; b8 = '0;
        iv2 = 0; ci2 = 0; or2 = 0; a2 = '0; b2 = '0;
        iv16 = 0; ci16 = 0; or16 = 0; a16 = '0; b16 = '0;
        @(posedge clk); #1;
        test_reset();
        test_latency_zero();
        test_carry_chain();
        test_cin_and_hold();
        test_back_to_back();
        test_async_reset();
        test_width2_exhaustive();
        test_width16_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
